if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, branch redirect, hazard stall and
// the IF/ID pipeline register with a running count of fetched instructions.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [23:0] br_imm24,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,      pc_d;
    logic [31:0] if_pc_q,   if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] cnt_q,     cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    // Sequential PC increment; wraps silently at the top of the address space.
    assign pc_plus4  = pc_q + 32'd4;
    // Word offset sign-extended and scaled to bytes, added modulo 2^32.
    assign br_target = br_base + {{6{br_imm24[23]}}, br_imm24, 2'b00};

    // Next-state selection: a taken branch beats freeze, freeze beats advance.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        cnt_d      = cnt_q;
        if (br_taken) begin
            pc_d       = br_target;
            if_pc_d    = '0;
            if_inst_d  = NOP_WORD;
            if_valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d       = pc_plus4;
            if_pc_d    = pc_plus4;
            if_inst_d  = mem_inst;
            if_valid_d = 1'b1;
            cnt_d      = cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_WORD;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory word index comes straight from the PC register only.
    assign mem_addr    = {2'b00, pc_q[31:2]};
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;
    assign fetch_count = cnt_q;

endmodule
